// File: rtl/lasd_exec_pkg.sv
// ---------------------------------------------------------------------------
// lasd_exec_pkg
//   Shared definitions for the register-file execution sequencer:
//   default data/address widths, ALU opcode encodings, the sequencer
//   state encoding and a small helper that tells whether an opcode
//   writes its result back to the register file.
// ---------------------------------------------------------------------------
package lasd_exec_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 3;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_MOVI = 3'b101;
   localparam logic [2:0] OP_SHL  = 3'b110;
   localparam logic [2:0] OP_CMP  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_t;

   // CMP only updates the flags/result; every other opcode writes back.
   function automatic logic op_writes(input logic [2:0] op);
      return (op != OP_CMP);
   endfunction

endpackage

// File: rtl/alu_8.sv
// ---------------------------------------------------------------------------
// alu_8
//   Purely combinational ALU used by the execution sequencer.
//   Ports:
//     op     in  3       opcode (OP_ADD .. OP_CMP)
//     a      in  DATA_W  operand from read port 1
//     b      in  DATA_W  operand from read port 2 (ignored by MOVI/SHL)
//     imm    in  DATA_W  immediate (MOVI only)
//     y      out DATA_W  result, modulo 2^DATA_W
//     carry  out 1       ADD carry-out, SUB/CMP borrow, SHL shifted-out bit
// ---------------------------------------------------------------------------
module alu_8
   import lasd_exec_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] y,
   output logic              carry
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   // One extra bit on each: the MSB of the sum is the carry-out, and the
   // MSB of the zero-extended difference is set exactly when a < b.
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      y     = '0;
      carry = 1'b0;
      case (op)
         OP_ADD: begin
            y     = sum[DATA_W-1:0];
            carry = sum[DATA_W];
         end
         OP_SUB, OP_CMP: begin
            y     = diff[DATA_W-1:0];
            carry = diff[DATA_W];
         end
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_MOVI: y = imm;
         OP_SHL: begin
            y     = {a[DATA_W-2:0], 1'b0};
            carry = a[DATA_W-1];
         end
         default: begin
            y     = '0;
            carry = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/regfile_exec_unit.sv
// ---------------------------------------------------------------------------
// regfile_exec_unit
//   Four-cycle execution sequencer sitting in front of an 8x8 register file.
//   Each instruction runs IDLE(accept) -> READ -> EXEC -> WB.
//   Ports:
//     clk, iRST_N          clock, asynchronous active-low reset
//     instr_valid/ready    instruction handshake (ready only in IDLE)
//     instr_op/dst/src1/src2/imm   instruction fields
//     ra1, ra2 / rd1, rd2  register file read addresses / read data
//     wa3, wd3, we3        register file write port
//     result               last computed ALU result
//     flag_zero/carry      flags of the last executed instruction
//     done                 one-cycle pulse while in WB
//     op_count             completed-instruction counter (wraps)
// ---------------------------------------------------------------------------
module regfile_exec_unit
   import lasd_exec_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              iRST_N,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        instr_op,
   input  logic [ADDR_W-1:0] instr_dst,
   input  logic [ADDR_W-1:0] instr_src1,
   input  logic [ADDR_W-1:0] instr_src2,
   input  logic [DATA_W-1:0] instr_imm,
   output logic [ADDR_W-1:0] ra1,
   output logic [ADDR_W-1:0] ra2,
   input  logic [DATA_W-1:0] rd1,
   input  logic [DATA_W-1:0] rd2,
   output logic [ADDR_W-1:0] wa3,
   output logic [DATA_W-1:0] wd3,
   output logic              we3,
   output logic [DATA_W-1:0] result,
   output logic              flag_zero,
   output logic              flag_carry,
   output logic              done,
   output logic [7:0]        op_count
);

   state_t            state_reg;
   state_t            state_next;

   logic [2:0]        op_reg;
   logic [ADDR_W-1:0] dst_reg;
   logic [DATA_W-1:0] imm_reg;
   logic [DATA_W-1:0] opa_reg;
   logic [DATA_W-1:0] opb_reg;

   logic [DATA_W-1:0] alu_y;
   logic              alu_carry;

   alu_8 #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op    (op_reg),
      .a     (opa_reg),
      .b     (opb_reg),
      .imm   (imm_reg),
      .y     (alu_y),
      .carry (alu_carry)
   );

   // Next-state and handshake logic.
   always_comb begin
      state_next  = state_reg;
      instr_ready = 1'b0;
      case (state_reg)
         S_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               state_next = S_READ;
            end
         end
         S_READ:  state_next = S_EXEC;
         S_EXEC:  state_next = S_WB;
         S_WB:    state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge iRST_N) begin
      if (!iRST_N) begin
         state_reg  <= S_IDLE;
         op_reg     <= OP_ADD;
         dst_reg    <= '0;
         imm_reg    <= '0;
         opa_reg    <= '0;
         opb_reg    <= '0;
         ra1        <= '0;
         ra2        <= '0;
         wa3        <= '0;
         wd3        <= '0;
         we3        <= 1'b0;
         result     <= '0;
         flag_zero  <= 1'b0;
         flag_carry <= 1'b0;
         done       <= 1'b0;
         op_count   <= 8'd0;
      end else begin
         state_reg <= state_next;
         // we3/done are set on the edge entering WB and cleared on the
         // edge leaving it, so they are high for exactly the WB cycle.
         we3  <= 1'b0;
         done <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (instr_valid) begin
                  op_reg  <= instr_op;
                  dst_reg <= instr_dst;
                  imm_reg <= instr_imm;
                  // Read addresses go straight out so rd1/rd2 are valid
                  // for the whole READ cycle.
                  ra1     <= instr_src1;
                  ra2     <= instr_src2;
               end
            end
            S_READ: begin
               opa_reg <= rd1;
               opb_reg <= rd2;
            end
            S_EXEC: begin
               result     <= alu_y;
               flag_zero  <= (alu_y == '0);
               flag_carry <= alu_carry;
               done       <= 1'b1;
               if (op_writes(op_reg)) begin
                  we3 <= 1'b1;
                  wa3 <= dst_reg;
                  wd3 <= alu_y;
               end
            end
            S_WB: begin
               op_count <= op_count + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
